// File: rtl/tuning_pkg.sv
// Shared types for the Q-tuning sequencer: FSM states, fault codes and a small
// constant helper used when sizing the shared timer.
package tuning_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StEngRst,
    StSettle,
    StMeasure,
    StEval,
    StLocked,
    StFault
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_TIMEOUT  = 2'b01,
    FC_UNSTABLE = 2'b10,
    FC_MAXITER  = 2'b11
  } fault_code_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter shared by the settle and measurement phases; saturates at zero
// and flags it. Load takes priority over decrement.
module cycle_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tuning_sequencer.sv
// Sequences one Q-tuning run around the search engine: engine reset, analog settling,
// Q measurement, convergence check and iteration handshake. All outputs are registered.
module tuning_sequencer
  import tuning_pkg::*;
#(
  parameter int unsigned BUS_WIDTH     = 10,
  parameter int unsigned TOL           = 1,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MEAS_TIMEOUT  = 1024,
  parameter int unsigned MAX_ITER      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [BUS_WIDTH-1:0]            q_desired,
  input  logic [BUS_WIDTH-1:0]            i_ref,
  input  logic                            engine_unstable,
  input  logic                            meas_done,
  input  logic [BUS_WIDTH-1:0]            q_measured,
  output logic                            engine_rst,
  output logic                            engine_ready,
  output logic                            meas_start,
  output logic                            busy,
  output logic                            locked,
  output logic                            fault,
  output logic [1:0]                      fault_code,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter_count
);

  localparam int unsigned IW   = $clog2(MAX_ITER + 1);
  localparam int unsigned TMax = max_u(SETTLE_CYCLES, MEAS_TIMEOUT);
  localparam int unsigned TW   = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [TW-1:0]        SettleLoad = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]        MeasLoad   = TW'(MEAS_TIMEOUT - 1);
  localparam logic [IW-1:0]        MaxIter    = IW'(MAX_ITER);
  localparam logic [BUS_WIDTH:0]   TolW       = (BUS_WIDTH + 1)'(TOL);

  state_t                state_q, state_d;
  fault_code_t           fc_q, fc_d;
  logic [BUS_WIDTH-1:0]  q_target_q, q_target_d;
  logic [BUS_WIDTH-1:0]  q_meas_q, q_meas_d;
  logic [BUS_WIDTH-1:0]  iref_prev_q;
  logic [IW-1:0]         iter_q, iter_d;
  logic                  engine_rst_q, engine_rst_d;
  logic                  engine_ready_q, engine_ready_d;
  logic                  meas_start_q, meas_start_d;
  logic                  busy_q, busy_d;
  logic                  locked_q, locked_d;
  logic                  fault_q, fault_d;

  logic                  tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]         tmr_val;
  logic                  iref_chg;
  logic signed [BUS_WIDTH:0] diff;
  logic [BUS_WIDTH:0]    adiff;
  logic                  within_tol;

  cycle_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  assign iref_chg = (i_ref != iref_prev_q);

  // One extra bit keeps the full +/- range, so a far-off reading can never alias near target
  always_comb begin
    diff       = $signed({1'b0, q_meas_q}) - $signed({1'b0, q_target_q});
    adiff      = diff[BUS_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    within_tol = (adiff <= TolW);
  end

  always_comb begin
    state_d        = state_q;
    fc_d           = fc_q;
    q_target_d     = q_target_q;
    q_meas_d       = q_meas_q;
    iter_d         = iter_q;
    engine_rst_d   = 1'b0;
    engine_ready_d = 1'b0;
    meas_start_d   = 1'b0;
    tmr_load       = 1'b0;
    tmr_dec        = 1'b0;
    tmr_val        = SettleLoad;

    unique case (state_q)
      StIdle, StLocked, StFault: begin
        if (start || ((state_q == StLocked) && (q_desired != q_target_q))) begin
          state_d      = StEngRst;
          q_target_d   = q_desired;
          iter_d       = '0;
          fc_d         = FC_NONE;
          engine_rst_d = 1'b1;
        end
      end
      StEngRst: begin
        state_d  = StSettle;
        tmr_load = 1'b1;
      end
      StSettle: begin
        if (iref_chg) begin
          tmr_load = 1'b1;
        end else if (tmr_zero) begin
          state_d      = StMeasure;
          meas_start_d = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = MeasLoad;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StMeasure: begin
        if (meas_done) begin
          q_meas_d = q_measured;
          state_d  = StEval;
        end else if (tmr_zero) begin
          state_d = StFault;
          fc_d    = FC_TIMEOUT;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      StEval: begin
        if (within_tol) begin
          state_d = StLocked;
        end else if (engine_unstable) begin
          state_d = StFault;
          fc_d    = FC_UNSTABLE;
        end else if (iter_q == MaxIter) begin
          state_d = StFault;
          fc_d    = FC_MAXITER;
        end else begin
          state_d        = StSettle;
          engine_ready_d = 1'b1;
          iter_d         = iter_q + IW'(1);
          tmr_load       = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d        = StIdle;
      fc_d           = FC_NONE;
      engine_rst_d   = 1'b0;
      engine_ready_d = 1'b0;
      meas_start_d   = 1'b0;
    end

    busy_d   = (state_d == StEngRst) || (state_d == StSettle) ||
               (state_d == StMeasure) || (state_d == StEval);
    locked_d = (state_d == StLocked);
    fault_d  = (state_d == StFault);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      fc_q           <= FC_NONE;
      q_target_q     <= '0;
      q_meas_q       <= '0;
      iref_prev_q    <= '0;
      iter_q         <= '0;
      engine_rst_q   <= 1'b0;
      engine_ready_q <= 1'b0;
      meas_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      locked_q       <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      fc_q           <= fc_d;
      q_target_q     <= q_target_d;
      q_meas_q       <= q_meas_d;
      iref_prev_q    <= i_ref;
      iter_q         <= iter_d;
      engine_rst_q   <= engine_rst_d;
      engine_ready_q <= engine_ready_d;
      meas_start_q   <= meas_start_d;
      busy_q         <= busy_d;
      locked_q       <= locked_d;
      fault_q        <= fault_d;
    end
  end

  assign engine_rst   = engine_rst_q;
  assign engine_ready = engine_ready_q;
  assign meas_start   = meas_start_q;
  assign busy         = busy_q;
  assign locked       = locked_q;
  assign fault        = fault_q;
  assign fault_code   = fc_q;
  assign iter_count   = iter_q;

endmodule

// File: tb/tb_tuning_sequencer.sv
// Bench for tuning_sequencer: table of complete runs against a reply model, plus
// hand-timed sequences for latency, timeout, abort, retarget and async reset.
module tb_tuning_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       engine_unstable = 1'b0;
  logic       meas_done = 1'b0;
  logic [9:0] q_desired = '0;
  logic [9:0] i_ref = '0;
  logic [9:0] q_measured = '0;
  logic       engine_rst, engine_ready, meas_start, busy, locked, fault;
  logic [1:0] fault_code;
  logic [2:0] iter_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reply model configuration (written by the stimulus process only)
  logic [9:0] resp_tbl [5];
  int         meas_dly = 3;
  bit         meas_en = 1'b1;

  // Reply model state (written by the model process only)
  int meas_cnt = 0;
  int meas_idx = 0;
  int ready_cnt = 0;
  int chg_cyc = -1;
  int gaps [$];

  typedef struct {
    logic [9:0] qd;
    logic [9:0] r [5];
    bit         uns;
    int         lk;
    int         ft;
    int         code;
    int         iter;
    int         rdy;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  tuning_sequencer #(
    .BUS_WIDTH     (10),
    .TOL           (1),
    .SETTLE_CYCLES (4),
    .MEAS_TIMEOUT  (8),
    .MAX_ITER      (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .q_desired       (q_desired),
    .i_ref           (i_ref),
    .engine_unstable (engine_unstable),
    .meas_done       (meas_done),
    .q_measured      (q_measured),
    .engine_rst      (engine_rst),
    .engine_ready    (engine_ready),
    .meas_start      (meas_start),
    .busy            (busy),
    .locked          (locked),
    .fault           (fault),
    .fault_code      (fault_code),
    .iter_count      (iter_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Engine + measurement model, acting on the falling edge so the DUT sees it next rise
  always @(negedge clk) begin
    meas_done = 1'b0;
    if (engine_rst) begin
      meas_idx  = 0;
      ready_cnt = 0;
      chg_cyc   = -1;
      gaps.delete();
    end
    if (engine_ready) begin
      ready_cnt++;
      i_ref   = i_ref + 10'd7;
      chg_cyc = cyc;
    end
    if (meas_cnt > 0) begin
      meas_cnt--;
      if (meas_cnt == 0 && meas_en) begin
        meas_done  = 1'b1;
        q_measured = resp_tbl[meas_idx];
        if (meas_idx < 4) meas_idx++;
      end
    end
    if (meas_start) begin
      meas_cnt = meas_dly;
      if (chg_cyc >= 0) gaps.push_back(cyc - chg_cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    chk(nm, int'(busy), 0);
  endtask

  task automatic wait_meas_start(input string nm);
    int n = 0;
    while (!meas_start && n < 40) begin
      step();
      n++;
    end
    chk(nm, int'(meas_start), 1);
  endtask

  task automatic set_resp(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                          input logic [9:0] d, input logic [9:0] e);
    resp_tbl[0] = a;
    resp_tbl[1] = b;
    resp_tbl[2] = c;
    resp_tbl[3] = d;
    resp_tbl[4] = e;
  endtask

  function automatic vec_t mk(input logic [9:0] qd, input logic [9:0] r0, input logic [9:0] r1,
                              input logic [9:0] r2, input logic [9:0] r3, input logic [9:0] r4,
                              input bit uns, input int lk, input int ft, input int code,
                              input int iter, input int rdy);
    vec_t v;
    v.qd = qd;
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3; v.r[4] = r4;
    v.uns = uns; v.lk = lk; v.ft = ft; v.code = code; v.iter = iter; v.rdy = rdy;
    return v;
  endfunction

  initial begin
    //            qd    r0    r1    r2    r3    r4  uns lk ft code it rdy
    vecs[0] = mk(110,  110,  110,  110,  110,  110, 0, 1, 0, 0, 0, 0);
    vecs[1] = mk(110,  100,  105,  109,  109,  109, 0, 1, 0, 0, 2, 2);
    vecs[2] = mk(110,    0,    0,    0,    0,    0, 0, 0, 1, 3, 4, 4);
    vecs[3] = mk(110,    0,    0,    0,    0,    0, 1, 0, 1, 2, 0, 0);
    vecs[4] = mk(  0,    1,    1,    1,    1,    1, 0, 1, 0, 0, 0, 0);
    vecs[5] = mk(  5,    7,    4,    4,    4,    4, 0, 1, 0, 0, 1, 1);
    vecs[6] = mk(1023,   0, 1022, 1022, 1022, 1022, 0, 1, 0, 0, 1, 1);
    vecs[7] = mk(  0, 1023,    0,    0,    0,    0, 0, 1, 0, 0, 1, 1);
    vecs[8] = mk(110,  108,  110,  110,  110,  110, 0, 1, 0, 0, 1, 1);
    vecs[9] = mk(110,  111,  111,  111,  111,  111, 1, 1, 0, 0, 0, 0);
    set_resp(110, 110, 110, 110, 110);

    // Reset state
    step();
    step();
    chk("rst_engine_rst", int'(engine_rst), 0);
    chk("rst_engine_ready", int'(engine_ready), 0);
    chk("rst_meas_start", int'(meas_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_fault_code", int'(fault_code), 0);
    chk("rst_iter", int'(iter_count), 0);
    rst = 1'b0;
    step();

    // Table of complete runs
    for (int i = 0; i < NV; i++) begin
      abort = 1'b1;
      step();
      abort = 1'b0;
      q_desired = vecs[i].qd;
      engine_unstable = vecs[i].uns;
      for (int j = 0; j < 5; j++) resp_tbl[j] = vecs[i].r[j];
      start = 1'b1;
      step();
      start = 1'b0;
      chk($sformatf("v%0d_busy_after_start", i), int'(busy), 1);
      wait_idle($sformatf("v%0d_done", i));
      chk($sformatf("v%0d_locked", i), int'(locked), vecs[i].lk);
      chk($sformatf("v%0d_fault", i), int'(fault), vecs[i].ft);
      chk($sformatf("v%0d_fault_code", i), int'(fault_code), vecs[i].code);
      chk($sformatf("v%0d_iter", i), int'(iter_count), vecs[i].iter);
      chk($sformatf("v%0d_ready_pulses", i), ready_cnt, vecs[i].rdy);
      chk($sformatf("v%0d_gap_count", i), gaps.size(), vecs[i].rdy);
      for (int j = 0; j < gaps.size(); j++)
        chk($sformatf("v%0d_iref_to_meas_start_%0d", i, j), gaps[j], 5);
      engine_unstable = 1'b0;
    end

    // Start latency, and start held during a run is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    q_desired = 110;
    set_resp(110, 110, 110, 110, 110);
    start = 1'b1;
    step();
    chk("lat_engine_rst_n1", int'(engine_rst), 1);
    chk("lat_busy_n1", int'(busy), 1);
    step();
    chk("lat_engine_rst_n2", int'(engine_rst), 0);
    step();
    step();
    chk("lat_meas_start_n4", int'(meas_start), 0);
    start = 1'b0;
    step();
    chk("lat_meas_start_n5", int'(meas_start), 0);
    chk("lat_no_restart", int'(engine_rst), 0);
    step();
    chk("lat_meas_start_n6", int'(meas_start), 1);
    step();
    chk("lat_meas_start_one_cycle", int'(meas_start), 0);
    wait_idle("lat_done");
    chk("lat_locked", int'(locked), 1);

    // Measurement timeout, then recovery by start from FAULT
    abort = 1'b1;
    step();
    abort = 1'b0;
    meas_en = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_meas_start("to_meas_start_seen");
    begin
      int n = 0;
      while (!fault && n < 20) begin
        step();
        n++;
      end
      chk("to_cycles_to_fault", n, 8);
    end
    chk("to_fault_code", int'(fault_code), 1);
    chk("to_busy", int'(busy), 0);
    meas_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("to_recover_engine_rst", int'(engine_rst), 1);
    chk("to_recover_fault_clr", int'(fault), 0);
    chk("to_recover_code_clr", int'(fault_code), 0);
    wait_idle("to_recover_done");
    chk("to_recover_locked", int'(locked), 1);

    // meas_done on the final timeout cycle beats the timeout
    abort = 1'b1;
    step();
    abort = 1'b0;
    meas_dly = 7;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("edge_done");
    chk("edge_locked", int'(locked), 1);
    chk("edge_fault", int'(fault), 0);
    meas_dly = 3;

    // Abort mid-SETTLE, then abort together with start
    abort = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_busy", int'(busy), 0);
    chk("ab_locked", int'(locked), 0);
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (meas_start) seen++;
      end
      chk("ab_no_meas_start", seen, 0);
    end
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_start_busy", int'(busy), 0);
    chk("ab_start_engine_rst", int'(engine_rst), 0);
    step();
    chk("ab_start_still_idle", int'(busy), 0);

    // Retarget while LOCKED
    q_desired = 110;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle("rt_first_done");
    chk("rt_first_locked", int'(locked), 1);
    resp_tbl[0] = 40;
    q_desired = 40;
    step();
    chk("rt_engine_rst", int'(engine_rst), 1);
    chk("rt_busy", int'(busy), 1);
    chk("rt_locked_drop", int'(locked), 0);
    wait_idle("rt_done");
    chk("rt_relocked", int'(locked), 1);
    chk("rt_iter", int'(iter_count), 0);

    // Asynchronous reset during MEASURE; the late reply must be ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    q_desired = 110;
    set_resp(110, 110, 110, 110, 110);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_meas_start("ar_meas_start_seen");
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("ar_busy_async", int'(busy), 0);
    chk("ar_meas_start_async", int'(meas_start), 0);
    chk("ar_locked_async", int'(locked), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    step();
    step();
    chk("ar_late_busy", int'(busy), 0);
    chk("ar_late_locked", int'(locked), 0);
    chk("ar_late_fault", int'(fault), 0);
    chk("ar_late_ready", int'(engine_ready), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
